dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data memory: the 1024×32 word array addressed by the low 10 bits of the ALU result. It shares the memory between the CPU load/store stage and a debug/loader port, issuing one access at a time. Each requester uses a request/grant handshake and receives a read-data-valid pulse. It drives the memory's enable, write-enable, address and write-data pins and returns the memory's synchronous read data.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_pick.sv | 36 +++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   state_e  : sequencer states (IDLE, ACC, RESP)
//   req_id_e : requester identity (REQ_CPU, REQ_DBG)
//   DefAddrW / DefDataW : default word-index and data widths
package dmem_arb_pkg;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_e;

  // Encoding matters: the pick block reports the winner as 1 = dbg.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
// Configuration macro: DMEM_ARB_RR_EN (round-robin on contention; default is fixed CPU priority).
// Ports:
//   cpu_req, dbg_req : pending requests
//   last_dbg         : (DMEM_ARB_RR_EN only) 1 when dbg was granted last
//   winner           : 0 = cpu, 1 = dbg (matches req_id_e encoding)
//   any_req          : at least one request pending
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
`ifdef DMEM_ARB_RR_EN
  input  logic last_dbg,
`endif
  output logic winner,
  output logic any_req
);

  assign any_req = cpu_req | dbg_req;

`ifdef DMEM_ARB_RR_EN
  // On contention the side not granted last wins.
  always_comb begin
    winner = REQ_CPU;
    if (cpu_req && dbg_req) begin
      winner = last_dbg ? REQ_CPU : REQ_DBG;
    end else if (dbg_req) begin
      winner = REQ_DBG;
    end
  end
`else
  assign winner = (dbg_req && !cpu_req) ? REQ_DBG : REQ_CPU;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for the single-port data memory.
// Configuration macro: DMEM_ARB_RR_EN (round-robin arbitration; default is fixed CPU priority).
// Ports:
//   clk, reset                           : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt     : CPU request handshake, one-cycle grant
//   cpu_rvalid, cpu_rdata                : CPU read return (rdata holds between pulses)
//   dbg_*                                : same for the debug/loader port
//   mem_en/we/addr/wdata, mem_rdata      : memory pins (read data valid cycle after mem_en)
//   busy                                 : sequencer not idle
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q;
  req_id_e           id_q;
  logic              we_q;
  logic [DATA_W-1:0] cpu_hold_q;
  logic [DATA_W-1:0] dbg_hold_q;
`ifdef DMEM_ARB_RR_EN
  req_id_e           last_q;
`endif

  logic              pick_win;
  logic              any_req;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              rd_acc;

  // Upper address bits are deliberately ignored (word index aliasing).
  logic addr_unused;
  assign addr_unused = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

  dmem_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
`ifdef DMEM_ARB_RR_EN
    .last_dbg (last_q == REQ_DBG),
`endif
    .winner   (pick_win),
    .any_req  (any_req)
  );

  assign pick_we    = pick_win ? dbg_we : cpu_we;
  assign pick_addr  = pick_win ? dbg_addr[ADDR_W-1:0] : cpu_addr[ADDR_W-1:0];
  assign pick_wdata = pick_win ? dbg_wdata : cpu_wdata;

  // A read in ACC must be followed by its RESP cycle; every other state may issue.
  assign rd_acc = (state_q == ACC) && !we_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      id_q       <= REQ_CPU;
      we_q       <= 1'b0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q     <= REQ_DBG;
`endif
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;

      // Keep the returned word visible after the rvalid pulse ends.
      if (cpu_rvalid) cpu_hold_q <= mem_rdata;
      if (dbg_rvalid) dbg_hold_q <= mem_rdata;

      if (rd_acc) begin
        state_q    <= RESP;
        cpu_rvalid <= (id_q == REQ_CPU);
        dbg_rvalid <= (id_q == REQ_DBG);
      end else if (any_req) begin
        state_q   <= ACC;
        id_q      <= req_id_e'(pick_win);
        we_q      <= pick_we;
        cpu_gnt   <= !pick_win;
        dbg_gnt   <= pick_win;
        mem_en    <= 1'b1;
        mem_we    <= pick_we;
        mem_addr  <= pick_addr;
        mem_wdata <= pick_wdata;
`ifdef DMEM_ARB_RR_EN
        last_q    <= req_id_e'(pick_win);
`endif
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_hold_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a transaction-level model checks every cycle,
// a vector table covers single accesses, hand sequences cover contention/reset/streams,
// and a random phase exercises mixed traffic.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we, busy;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_arr [0:1023] = '{default: '0};

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // Single-port synchronous memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model state (transaction level).
  logic [31:0] gold [0:1023];
  logic        m_rd, m_rd_dbg, last_win_dbg;
  logic [31:0] pend, last_cr, last_dr;
  // Inputs as seen at the most recent clock edge.
  logic        p_reset, p_cpu_req, p_cpu_we, p_dbg_req, p_dbg_we;
  logic [31:0] p_cpu_addr, p_cpu_wdata, p_dbg_addr, p_dbg_wdata;

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [9:0]  exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;
  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic dbg, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (dbg) begin
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
  endtask

  // Predict this cycle's outputs from the inputs seen at the last edge and compare.
  task automatic monitor();
    logic rv_c, rv_d, g_any, w_dbg, we;
    logic [9:0]  a;
    logic [31:0] wd;
    rv_c = 0; rv_d = 0; g_any = 0; w_dbg = 0; we = 0; a = '0; wd = '0;
    if (p_reset) begin
      m_rd = 0; last_cr = '0; last_dr = '0; last_win_dbg = 1'b1;
    end else begin
      rv_c  = m_rd & ~m_rd_dbg;
      rv_d  = m_rd & m_rd_dbg;
      g_any = (p_cpu_req | p_dbg_req) & ~m_rd;
      w_dbg = p_dbg_req & (~p_cpu_req | (RrEn & ~last_win_dbg));
      if (rv_c) last_cr = pend;
      if (rv_d) last_dr = pend;
      if (g_any) begin
        we = w_dbg ? p_dbg_we : p_cpu_we;
        a  = w_dbg ? p_dbg_addr[9:0] : p_cpu_addr[9:0];
        wd = w_dbg ? p_dbg_wdata : p_cpu_wdata;
        if (we) gold[a] = wd;
        else    pend = gold[a];
        last_win_dbg = w_dbg;
        m_rd = ~we;
        m_rd_dbg = w_dbg;
      end else begin
        m_rd = 0;
      end
    end
    chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, g_any & ~w_dbg});
    chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, g_any & w_dbg});
    chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, rv_c});
    chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, rv_d});
    chk("busy", {31'b0, busy}, {31'b0, g_any | rv_c | rv_d});
    chk("mem_en", {31'b0, mem_en}, {31'b0, g_any});
    chk("mem_we", {31'b0, mem_we}, {31'b0, g_any & we});
    chk("mem_addr", {22'b0, mem_addr}, {22'b0, a});
    chk("mem_wdata", mem_wdata, wd);
    chk("cpu_rdata", cpu_rdata, last_cr);
    chk("dbg_rdata", dbg_rdata, last_dr);
  endtask

  task automatic step();
    p_reset = reset;
    p_cpu_req = cpu_req; p_cpu_we = cpu_we; p_cpu_addr = cpu_addr; p_cpu_wdata = cpu_wdata;
    p_dbg_req = dbg_req; p_dbg_we = dbg_we; p_dbg_addr = dbg_addr; p_dbg_wdata = dbg_wdata;
    @(posedge clk);
    #1;
    monitor();
  endtask

  logic first_dbg;

  initial begin
    for (int i = 0; i < 1024; i++) gold[i] = '0;
    m_rd = 0; m_rd_dbg = 0; last_win_dbg = 1; pend = '0; last_cr = '0; last_dr = '0;
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 10'h005, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         10'h005, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0403, 32'h1234_5678, 10'h003, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,         10'h003, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FC05, 32'h0,         10'h005, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_03FF, 32'hAAAA_5555, 10'h3FF, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_07FF, 32'h0,         10'h3FF, 32'hAAAA_5555};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0800, 32'h0BAD_F00D, 10'h000, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         10'h000, 32'h0BAD_F00D};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;
    step();

    // Single accesses from idle: grant one cycle after request, read data one later.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].dbg, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      step();
      chk("tbl_gnt", {31'b0, vecs[i].dbg ? dbg_gnt : cpu_gnt}, 32'd1);
      chk("tbl_addr", {22'b0, mem_addr}, {22'b0, vecs[i].exp_addr});
      chk("tbl_we", {31'b0, mem_we}, {31'b0, vecs[i].we});
      drive(vecs[i].dbg, 1'b0, 1'b0, 32'h0, 32'h0);
      if (!vecs[i].we) begin
        step();
        chk("tbl_rvalid", {31'b0, vecs[i].dbg ? dbg_rvalid : cpu_rvalid}, 32'd1);
        chk("tbl_rdata", vecs[i].dbg ? dbg_rdata : cpu_rdata, vecs[i].exp_rdata);
      end
      step();
    end

    // Simultaneous reads: loser granted in the cycle after the winner's rvalid.
    first_dbg = RrEn & ~last_win_dbg;
    drive(1'b0, 1'b1, 1'b0, 32'h5, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h3, 32'h0);
    step();
    chk("sim_first_gnt", {31'b0, first_dbg ? dbg_gnt : cpu_gnt}, 32'd1);
    drive(first_dbg, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("sim_first_rv", {31'b0, first_dbg ? dbg_rvalid : cpu_rvalid}, 32'd1);
    chk("sim_first_rd", first_dbg ? dbg_rdata : cpu_rdata,
        first_dbg ? 32'h1234_5678 : 32'hDEAD_BEEF);
    step();
    chk("sim_second_gnt", {31'b0, first_dbg ? cpu_gnt : dbg_gnt}, 32'd1);
    drive(~first_dbg, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("sim_second_rd", first_dbg ? cpu_rdata : dbg_rdata,
        first_dbg ? 32'hDEAD_BEEF : 32'h1234_5678);
    step();

    // Back-to-back dbg writes: a grant every cycle, busy throughout.
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hC0DE_0000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b2b_gnt", {31'b0, dbg_gnt}, 32'd1);
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      if (i < 3) drive(1'b1, 1'b1, 1'b1, 32'h11 + i, 32'hC0DE_0001 + i);
      else       drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    step();
    chk("b2b_idle", {31'b0, busy}, 32'd0);

    // Reset while a CPU read is in flight: no rvalid, everything cleared.
    drive(1'b0, 1'b1, 1'b0, 32'h3FF, 32'h0);
    step();
    chk("rst_gnt", {31'b0, cpu_gnt}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    chk("rst_no_rv", {31'b0, cpu_rvalid}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h3FF, 32'h0);
    step();
    chk("rst_regnt", {31'b0, cpu_gnt}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("rst_rerd", cpu_rdata, 32'hAAAA_5555);
    step();

`ifndef DMEM_ARB_RR_EN
    // Fixed priority: a continuously requesting CPU starves dbg.
    drive(1'b1, 1'b1, 1'b0, 32'h5, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h3, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("starve_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
      chk("starve_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
      if (i == 9) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      chk("starve_rv", {31'b0, cpu_rvalid}, 32'd1);
      chk("starve_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    end
    step();
    chk("starve_release", {31'b0, dbg_gnt}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
`endif

    // Random mixed traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic cg, dg;
      step();
      cg = cpu_gnt;
      dg = dbg_gnt;
      reset = ($urandom_range(0, 79) == 0);
      if (cg || !cpu_req) begin
        if ($urandom_range(0, 1) == 1)
          drive(1'b0, 1'b1, 1'($urandom_range(0, 1)),
                {$urandom_range(0, 3), 2'b00, 20'h0, 4'h0, 4'($urandom_range(0, 15))},
                $urandom);
        else
          drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (dg || !dbg_req) begin
        if ($urandom_range(0, 1) == 1)
          drive(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                {$urandom_range(0, 3), 2'b00, 20'h0, 4'h0, 4'($urandom_range(0, 15))},
                $urandom);
        else
          drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
